// File: rtl/clock_display_scan_if.sv
// Time bus into the display stage and the multiplexed 7-segment drive coming out of it.
// The master drives the time fields and watches the display; the slave is the scan block.
interface clock_display_scan_if;
   logic [4:0] hora;
   logic [5:0] minutos;
   logic [5:0] segundos;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_tick;

   modport master (
      output hora, minutos, segundos,
      input  an, seg, dp, frame_tick
   );

   modport slave (
      input  hora, minutos, segundos,
      output an, seg, dp, frame_tick
   );
endinterface

// File: rtl/clock_display_scan.sv
// Six-digit HH.MM.SS scanner for a common-anode 7-segment display.
// Snapshots the time once per frame, converts it to BCD and drives one digit per scan slot.
//
// state    | meaning
// ---------+-----------------------------------------
// D_SEC_U  | seconds units digit active (an[0] low)
// D_SEC_T  | seconds tens digit active  (an[1] low)
// D_MIN_U  | minutes units digit active (an[2] low)
// D_MIN_T  | minutes tens digit active  (an[3] low)
// D_HR_U   | hours units digit active   (an[4] low)
// D_HR_T   | hours tens digit active    (an[5] low); leaving it wraps the frame
module clock_display_scan #(
   parameter int SCAN_DIV   = 4,
   parameter int LEAD_BLANK = 1,
   parameter int DP_EN      = 1
) (
   input  logic                  clk,
   input  logic                  res,
   clock_display_scan_if.slave   bus
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [2:0] {
      D_SEC_U = 3'd0,
      D_SEC_T = 3'd1,
      D_MIN_U = 3'd2,
      D_MIN_T = 3'd3,
      D_HR_U  = 3'd4,
      D_HR_T  = 3'd5
   } digit_t;

   digit_t          state;
   digit_t          state_nxt;
   logic [PW-1:0]   presc;
   logic            tick;
   logic            wrap;

   logic [4:0]      snap_h;
   logic [5:0]      snap_m;
   logic [5:0]      snap_s;
   logic [4:0]      load_h;
   logic [5:0]      load_m;
   logic [5:0]      load_s;

   logic [7:0]      bcd_h;
   logic [7:0]      bcd_m;
   logic [7:0]      bcd_s;

   logic [5:0]      an_d;
   logic [6:0]      seg_d;
   logic            dp_d;
   logic            field_ok;
   logic [3:0]      digit;

   logic [5:0]      an_q;
   logic [6:0]      seg_q;
   logic            dp_q;
   logic            frame_tick_q;

   // Tens/units by successive comparison; covers the full 0..63 input range.
   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      logic [3:0] t;
      logic [5:0] r;
      if (v >= 6'd60) begin
         t = 4'd6; r = v - 6'd60;
      end else if (v >= 6'd50) begin
         t = 4'd5; r = v - 6'd50;
      end else if (v >= 6'd40) begin
         t = 4'd4; r = v - 6'd40;
      end else if (v >= 6'd30) begin
         t = 4'd3; r = v - 6'd30;
      end else if (v >= 6'd20) begin
         t = 4'd2; r = v - 6'd20;
      end else if (v >= 6'd10) begin
         t = 4'd1; r = v - 6'd10;
      end else begin
         t = 4'd0; r = v;
      end
      return {t, r[3:0]};
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   assign tick = (presc == PW'(SCAN_DIV - 1));
   assign wrap = tick && (state == D_HR_T);

   // Digit 0 of a new frame must already show the value captured on the wrap edge.
   assign load_h = wrap ? bus.hora     : snap_h;
   assign load_m = wrap ? bus.minutos  : snap_m;
   assign load_s = wrap ? bus.segundos : snap_s;

   assign bcd_h = to_bcd({1'b0, load_h});
   assign bcd_m = to_bcd(load_m);
   assign bcd_s = to_bcd(load_s);

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         presc  <= '0;
         state  <= D_SEC_U;
         snap_h <= '0;
         snap_m <= '0;
         snap_s <= '0;
      end else begin
         presc  <= tick ? '0 : presc + 1'b1;
         state  <= state_nxt;
         snap_h <= load_h;
         snap_m <= load_m;
         snap_s <= load_s;
      end
   end

   always_comb begin
      state_nxt = state;
      if (tick) begin
         case (state)
            D_SEC_U: state_nxt = D_SEC_T;
            D_SEC_T: state_nxt = D_MIN_U;
            D_MIN_U: state_nxt = D_MIN_T;
            D_MIN_T: state_nxt = D_HR_U;
            D_HR_U:  state_nxt = D_HR_T;
            D_HR_T:  state_nxt = D_SEC_U;
            default: state_nxt = D_SEC_U;
         endcase
      end
   end

   always_comb begin
      field_ok = 1'b1;
      digit    = 4'd0;
      case (state_nxt)
         D_SEC_U: begin field_ok = (load_s <= 6'd59); digit = bcd_s[3:0]; end
         D_SEC_T: begin field_ok = (load_s <= 6'd59); digit = bcd_s[7:4]; end
         D_MIN_U: begin field_ok = (load_m <= 6'd59); digit = bcd_m[3:0]; end
         D_MIN_T: begin field_ok = (load_m <= 6'd59); digit = bcd_m[7:4]; end
         D_HR_U:  begin field_ok = (load_h <= 5'd23); digit = bcd_h[3:0]; end
         D_HR_T:  begin field_ok = (load_h <= 5'd23); digit = bcd_h[7:4]; end
         default: begin field_ok = 1'b1;              digit = 4'd0;       end
      endcase

      an_d = ~(6'b000001 << state_nxt);

      if (!field_ok)
         seg_d = SEG_DASH;
      else if ((LEAD_BLANK != 0) && (state_nxt == D_HR_T) && (digit == 4'd0))
         seg_d = SEG_BLANK;
      else
         seg_d = seg7(digit);

      // Separator dots sit on minute-units and hour-units, but never on a dash.
      dp_d = !((DP_EN != 0) && field_ok &&
               ((state_nxt == D_MIN_U) || (state_nxt == D_HR_U)));
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         an_q         <= 6'b111110;
         seg_q        <= 7'b1000000;
         dp_q         <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         frame_tick_q <= wrap;
         if (tick) begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
         end
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: two instances (blanking+dots on, and both off) checked every
// cycle against an arithmetic display model, plus directed literal checks of scan timing.
module tb_clock_display_scan;
   logic clk = 1'b0;
   logic res = 1'b0;
   int   tests  = 0;
   int   failed = 0;
   bit   started = 1'b0;

   clock_display_scan_if ifa ();
   clock_display_scan_if ifb ();

   clock_display_scan #(.SCAN_DIV(4), .LEAD_BLANK(1), .DP_EN(1)) dut_a (
      .clk (clk), .res (res), .bus (ifa.slave)
   );
   clock_display_scan #(.SCAN_DIV(4), .LEAD_BLANK(0), .DP_EN(0)) dut_b (
      .clk (clk), .res (res), .bus (ifb.slave)
   );

   always #5 clk = ~clk;

   logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   // Model: count edges since reset; every 4th edge moves to the next digit, every 24th
   // edge loads a fresh snapshot of the inputs.
   int m_cyc = 0;
   int m_h = 0, m_m = 0, m_s = 0;

   always @(posedge clk or negedge res) begin
      if (!res) begin
         m_cyc = 0; m_h = 0; m_m = 0; m_s = 0;
      end else begin
         m_cyc++;
         if (m_cyc % 24 == 0) begin
            m_h = int'(ifa.hora); m_m = int'(ifa.minutos); m_s = int'(ifa.segundos);
         end
      end
   end

   function automatic logic [13:0] model_out(int idx, int h, int m, int s, bit lead, bit dpen);
      int v, lim, d;
      logic [6:0] sg;
      logic dpv;
      logic [5:0] a;
      v   = (idx < 2) ? s : (idx < 4) ? m : h;
      lim = (idx < 4) ? 59 : 23;
      d   = (idx % 2 == 0) ? v % 10 : v / 10;
      a   = ~(6'd1 << idx);
      if (v > lim) begin
         sg = 7'b0111111; dpv = 1'b1;
      end else begin
         sg = segtab[d];
         if (idx == 5 && lead && d == 0) sg = 7'b1111111;
         dpv = (dpen && (idx == 2 || idx == 4)) ? 1'b0 : 1'b1;
      end
      return {a, sg, dpv};
   endfunction

   always @(negedge clk) begin
      if (started) begin
         int idx;
         logic ft;
         logic [14:0] ea, eb, ga, gb;
         idx = (m_cyc / 4) % 6;
         ft  = (m_cyc > 0) && (m_cyc % 24 == 0);
         ea  = {model_out(idx, m_h, m_m, m_s, 1'b1, 1'b1), ft};
         eb  = {model_out(idx, m_h, m_m, m_s, 1'b0, 1'b0), ft};
         ga  = {ifa.an, ifa.seg, ifa.dp, ifa.frame_tick};
         gb  = {ifb.an, ifb.seg, ifb.dp, ifb.frame_tick};
         tests += 2;
         if (ga !== ea) begin
            failed++;
            $display("FAIL model_a t=%0t an/seg/dp/ft got %b expected %b", $time, ga, ea);
         end
         if (gb !== eb) begin
            failed++;
            $display("FAIL model_b t=%0t an/seg/dp/ft got %b expected %b", $time, gb, eb);
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic set_time(input int h, input int m, input int s);
      ifa.hora = 5'(h); ifa.minutos = 6'(m); ifa.segundos = 6'(s);
      ifb.hora = 5'(h); ifb.minutos = 6'(m); ifb.segundos = 6'(s);
   endtask

   task automatic step_to(input int d);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!((m_cyc % 4 == 0) && ((m_cyc / 4) % 6 == d)) && n < 200);
      if (n >= 200) begin
         tests++; failed++;
         $display("FAIL step_to timeout: digit %0d not reached", d);
      end
   endtask

   logic [5:0] an_seq  [6] = '{6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111, 6'b111110};
   logic [6:0] dec_seq [6] = '{7'b0100100, 7'b0011001, 7'b1111000, 7'b1000000, 7'b0110000, 7'b1111001};
   logic       dp_seq  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [6:0] max_seq [6] = '{7'b0010000, 7'b0010010, 7'b0010000, 7'b0010010, 7'b0110000, 7'b0100100};
   logic [6:0] oor_seq [6] = '{7'b0111111, 7'b0111111, 7'b1111000, 7'b1000000, 7'b0111111, 7'b0111111};

   initial begin
      set_time(0, 0, 0);
      repeat (2) @(posedge clk);
      #1 started = 1'b1;
      chk("reset_out", {ifa.an, ifa.seg, ifa.dp, ifa.frame_tick}, {6'b111110, 7'b1000000, 1'b1, 1'b0});
      @(negedge clk); #1 res = 1'b1;
      set_time(13, 7, 42);

      // Scan timing from release, then the 13:07:42 frame.
      for (int k = 1; k <= 24; k++) begin
         @(posedge clk); #1;
         if (k == 3)  chk("an_hold_c3", ifa.an, 6'b111110);
         if (k % 4 == 0) chk($sformatf("an_c%0d", k), ifa.an, an_seq[k/4-1]);
         if (k == 23) chk("ft_c23", ifa.frame_tick, 1'b0);
         if (k == 24) chk("ft_c24", ifa.frame_tick, 1'b1);
      end
      chk("dec_d0", {ifa.seg, ifa.dp}, {dec_seq[0], dp_seq[0]});
      @(posedge clk); #1 chk("ft_c25", ifa.frame_tick, 1'b0);
      for (int d = 1; d < 6; d++) begin
         step_to(d);
         chk($sformatf("dec_d%0d", d), {ifa.seg, ifa.dp}, {dec_seq[d], dp_seq[d]});
      end

      // Leading blank on hour tens, instance b has blanking disabled.
      set_time(5, 7, 42);
      step_to(0); step_to(5);
      chk("blank_a", {ifa.an, ifa.seg}, {6'b011111, 7'b1111111});
      chk("noblank_b", {ifb.an, ifb.seg}, {6'b011111, 7'b1000000});

      // Out-of-range seconds and hours.
      set_time(24, 7, 60);
      for (int d = 0; d < 6; d++) begin
         step_to(d);
         chk($sformatf("oor_d%0d", d), ifa.seg, oor_seq[d]);
      end

      // Mid-frame input change waits for the next snapshot.
      set_time(13, 7, 42);
      step_to(0); step_to(1);
      ifa.minutos = 6'd8; ifb.minutos = 6'd8;
      step_to(2); chk("tear_d2", ifa.seg, 7'b1111000);
      step_to(3); chk("tear_d3", ifa.seg, 7'b1000000);
      step_to(0); chk("tear_ft", ifa.frame_tick, 1'b1);
      step_to(2); chk("tear_new_d2", ifa.seg, 7'b0000000);
      step_to(3); chk("tear_new_d3", ifa.seg, 7'b1000000);

      // 23:59:59
      set_time(23, 59, 59);
      step_to(5);
      for (int d = 0; d < 6; d++) begin
         step_to(d);
         chk($sformatf("max_d%0d", d), ifa.seg, max_seq[d]);
      end

      // 00:00:00
      set_time(0, 0, 0);
      step_to(5);
      for (int d = 0; d < 5; d++) begin
         step_to(d);
         chk($sformatf("zero_d%0d", d), ifa.seg, 7'b1000000);
      end
      step_to(5);
      chk("zero_d5_a", ifa.seg, 7'b1111111);
      chk("zero_d5_b", ifb.seg, 7'b1000000);

      // Asynchronous reset in the middle of a digit slot.
      set_time(23, 59, 59);
      step_to(3);
      @(posedge clk); #1;
      @(posedge clk); #1 res = 1'b0;
      #1 chk("async_rst", {ifa.an, ifa.seg, ifa.dp, ifa.frame_tick}, {6'b111110, 7'b1000000, 1'b1, 1'b0});
      @(negedge clk); #1 res = 1'b1;
      step_to(1); chk("post_rst_d1", ifa.seg, 7'b1000000);
      step_to(0); chk("post_rst_wrap", {ifa.seg, ifa.frame_tick}, {7'b0010000, 1'b1});

      repeat (8) @(posedge clk);
      #1 started = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
